// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Round-robin scheduler sharing one UART TX serializer among NUM_REQ byte
// requesters. One byte is captured from the granted requester, handed to the
// TX with a one-cycle TX_DATA_VALID pulse, and the arbiter then follows
// TX_BUSY high->low before the next grant. If TX_BUSY never rises within
// BUSY_TIMEOUT cycles the byte is dropped and TIMEOUT_ERR pulses.
// Optional feature: define UART_ARB_LOCK_EN to let a requester holding
// REQ_LOCK keep the TX for consecutive bytes (burst lock).
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [NUM_REQ-1:0]            REQ_VALID,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]            REQ_LOCK,
    output logic [NUM_REQ-1:0]            REQ_ACK,
    output logic [NUM_REQ-1:0]            GRANT,
    input  logic                          PAR_EN_CFG,
    output logic [DATA_WIDTH-1:0]         TX_P_DATA,
    output logic                          TX_DATA_VALID,
    output logic                          TX_PAR_EN,
    input  logic                          TX_BUSY,
    output logic                          ARB_BUSY,
    output logic                          TIMEOUT_ERR
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t                 state, state_nxt;
    logic [IDX_W-1:0]       last_grant, last_grant_nxt;
    logic [IDX_W-1:0]       gnt_idx, gnt_idx_nxt;
    logic [NUM_REQ-1:0]     grant_q, grant_nxt;
    logic [NUM_REQ-1:0]     ack_q, ack_nxt;
    logic [DATA_WIDTH-1:0]  data_q, data_nxt;
    logic                   par_q, par_nxt;
    logic                   dv_q, dv_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [IDX_W-1:0]       rr_idx, cand;
    logic                   rr_found;
    logic                   timeout;

`ifndef UART_ARB_LOCK_EN
    // Lock inputs have no function when burst lock is not built in.
    logic unused_lock;
    assign unused_lock = ^REQ_LOCK;
`endif

    // Round-robin pick: first valid requester after last_grant, wrapping.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant) + k) % NUM_REQ);
            if (!rr_found && REQ_VALID[cand]) begin
                rr_found = 1'b1;
                rr_idx   = cand;
            end
        end
    end

    // TX never acknowledged the byte: only while waiting for busy to rise.
    assign timeout = (state == WAIT_HI) && !TX_BUSY && (cnt >= 8'(BUSY_TIMEOUT));

    // Next-state and next-output logic for the transfer FSM.
    always_comb begin
        state_nxt      = state;
        last_grant_nxt = last_grant;
        gnt_idx_nxt    = gnt_idx;
        grant_nxt      = grant_q;
        ack_nxt        = '0;
        data_nxt       = data_q;
        par_nxt        = par_q;
        dv_nxt         = 1'b0;
        cnt_nxt        = cnt;
        case (state)
            IDLE: begin
                if (rr_found && !TX_BUSY) begin
                    gnt_idx_nxt = rr_idx;
                    grant_nxt   = NUM_REQ'(1) << rr_idx;
                    ack_nxt     = NUM_REQ'(1) << rr_idx;
                    data_nxt    = REQ_DATA[rr_idx*DATA_WIDTH +: DATA_WIDTH];
                    par_nxt     = PAR_EN_CFG;
                    state_nxt   = ISSUE;
                end
            end
            ISSUE: begin
                dv_nxt    = 1'b1;
                cnt_nxt   = '0;
                state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (TX_BUSY) begin
                    state_nxt = WAIT_LO;
                end else if (timeout) begin
                    // Byte is dropped; advance the pointer so the others get a turn.
                    last_grant_nxt = gnt_idx;
                    grant_nxt      = '0;
                    state_nxt      = IDLE;
                end else if (cnt != 8'hFF) begin
                    cnt_nxt = cnt + 8'd1;
                end
            end
            WAIT_LO: begin
                if (!TX_BUSY) begin
                    last_grant_nxt = gnt_idx;
                    grant_nxt      = '0;
                    state_nxt      = IDLE;
`ifdef UART_ARB_LOCK_EN
                    // Locked owner with another byte pending keeps the TX.
                    if (REQ_LOCK[gnt_idx] && REQ_VALID[gnt_idx]) begin
                        grant_nxt = NUM_REQ'(1) << gnt_idx;
                        ack_nxt   = NUM_REQ'(1) << gnt_idx;
                        data_nxt  = REQ_DATA[gnt_idx*DATA_WIDTH +: DATA_WIDTH];
                        par_nxt   = PAR_EN_CFG;
                        state_nxt = ISSUE;
                    end
`endif
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                data_nxt  = '0;
                par_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any byte in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_REQ - 1);
            gnt_idx    <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            dv_q       <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_grant_nxt;
            gnt_idx    <= gnt_idx_nxt;
            grant_q    <= grant_nxt;
            ack_q      <= ack_nxt;
            data_q     <= data_nxt;
            par_q      <= par_nxt;
            dv_q       <= dv_nxt;
            cnt        <= cnt_nxt;
        end
    end

    assign REQ_ACK       = ack_q;
    assign GRANT         = grant_q;
    assign TX_P_DATA     = data_q;
    assign TX_DATA_VALID = dv_q;
    assign TX_PAR_EN     = par_q;
    assign ARB_BUSY      = (state != IDLE);
    assign TIMEOUT_ERR   = timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: table of round-robin vectors plus
// hand-written sequences for timeout, busy-in-idle, mid-transfer reset
// and burst lock. Expected bytes are queued when requests are raised and
// popped on every TX_DATA_VALID pulse.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;
    localparam int TO = 15;

    logic              CLK = 1'b0;
    logic              RST = 1'b0;
    logic [NR-1:0]     REQ_VALID;
    logic [NR*DW-1:0]  REQ_DATA;
    logic [NR-1:0]     REQ_LOCK;
    logic [NR-1:0]     REQ_ACK;
    logic [NR-1:0]     GRANT;
    logic              PAR_EN_CFG;
    logic [DW-1:0]     TX_P_DATA;
    logic              TX_DATA_VALID;
    logic              TX_PAR_EN;
    logic              TX_BUSY;
    logic              ARB_BUSY;
    logic              TIMEOUT_ERR;

    uart_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BUSY_TIMEOUT(TO)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA),
        .REQ_LOCK(REQ_LOCK), .REQ_ACK(REQ_ACK), .GRANT(GRANT),
        .PAR_EN_CFG(PAR_EN_CFG), .TX_P_DATA(TX_P_DATA),
        .TX_DATA_VALID(TX_DATA_VALID), .TX_PAR_EN(TX_PAR_EN),
        .TX_BUSY(TX_BUSY), .ARB_BUSY(ARB_BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    // TX model: busy for tx_len cycles after each DATA_VALID pulse.
    int         tx_len   = 11;
    bit         tx_dead  = 1'b0;
    bit         tx_force = 1'b0;
    logic [7:0] busy_cnt;
    always @(posedge CLK or negedge RST) begin
        if (!RST) busy_cnt <= '0;
        else if (TX_DATA_VALID && !tx_dead) busy_cnt <= 8'(tx_len);
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 8'd1;
    end
    assign TX_BUSY = (busy_cnt != 0) || tx_force;

    typedef struct { int idx; logic [7:0] data; logic par; } exp_t;
    exp_t exp_q[$];

    typedef struct {
        bit rst; logic [3:0] valid; logic [7:0] base; bit par;
        int len; int cnt; int n; logic [31:0] order;
    } vec_t;
    vec_t tv [8];

    int n_chk = 0, n_pass = 0;
    int ack_cnt = 0, dv_cnt = 0, to_cnt = 0;
    int rem [NR];
    int lock_cnt [NR];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input int idx, input logic [7:0] d, input logic p);
        exp_t e;
        e.idx = idx; e.data = d; e.par = p;
        exp_q.push_back(e);
    endtask

    task automatic drive_req();
        for (int i = 0; i < NR; i++) begin
            REQ_VALID[i] = (rem[i] != 0);
            REQ_LOCK[i]  = (lock_cnt[i] != 0);
        end
    endtask

    task automatic set_data(input logic [7:0] base);
        for (int i = 0; i < NR; i++) REQ_DATA[i*DW +: DW] = base + 8'(i);
    endtask

    // One cycle: sample on the falling edge, score, then update requesters.
    task automatic tick();
        exp_t e;
        @(negedge CLK);
        if (REQ_ACK != '0) begin
            ack_cnt++;
            check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check("ack_idx", 32'(REQ_ACK), 32'd1 << exp_q[0].idx);
            check("grant_at_ack", 32'(GRANT), 32'(REQ_ACK));
        end
        if (TX_DATA_VALID) begin
            dv_cnt++;
            check("dv_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("tx_data", 32'(TX_P_DATA), 32'(e.data));
                check("tx_par", 32'(TX_PAR_EN), 32'(e.par));
                check("grant_at_dv", 32'(GRANT), 32'd1 << e.idx);
            end
        end
        if (TIMEOUT_ERR) to_cnt++;
        for (int i = 0; i < NR; i++) begin
            if (REQ_ACK[i]) begin
                if (rem[i] > 0) rem[i]--;
                if (lock_cnt[i] > 0) lock_cnt[i]--;
                // Scramble the byte once captured; the TX must keep the latched value.
                if (rem[i] == 0) REQ_DATA[i*DW +: DW] = ~REQ_DATA[i*DW +: DW];
            end
        end
        drive_req();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || REQ_VALID != '0 || ARB_BUSY || TX_BUSY) && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_done"}, 32'(n < 3000), 32'd1);
        check({name, "_grant0"}, 32'(GRANT), 32'd0);
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ack"}, 32'(REQ_ACK), 32'd0);
        check({name, "_grant"}, 32'(GRANT), 32'd0);
        check({name, "_data"}, 32'(TX_P_DATA), 32'd0);
        check({name, "_dv"}, 32'(TX_DATA_VALID), 32'd0);
        check({name, "_par"}, 32'(TX_PAR_EN), 32'd0);
        check({name, "_busy"}, 32'(ARB_BUSY), 32'd0);
        check({name, "_to"}, 32'(TIMEOUT_ERR), 32'd0);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        for (int i = 0; i < NR; i++) begin rem[i] = 0; lock_cnt[i] = 0; end
        drive_req();
        tx_dead = 1'b0; tx_force = 1'b0;
        exp_q.delete();
        #1;
        check_outputs_zero("reset");
        tick();
        tick();
        RST = 1'b1;
    endtask

    initial begin
        int a0, d0, t0, n;
        tv[0] = '{1'b1, 4'b0001, 8'hA5, 1'b0, 11, 1, 1, 32'h0};
        tv[1] = '{1'b1, 4'b1111, 8'h10, 1'b1, 4,  2, 8, 32'h32103210};
        tv[2] = '{1'b0, 4'b0110, 8'h20, 1'b0, 3,  1, 2, 32'h21};
        tv[3] = '{1'b0, 4'b1001, 8'h30, 1'b1, 6,  1, 2, 32'h03};
        tv[4] = '{1'b0, 4'b0101, 8'h40, 1'b0, 1,  1, 2, 32'h02};
        tv[5] = '{1'b0, 4'b0001, 8'h50, 1'b1, 2,  1, 1, 32'h0};
        tv[6] = '{1'b0, 4'b1110, 8'h60, 1'b0, 5,  1, 3, 32'h321};
        tv[7] = '{1'b0, 4'b1000, 8'h70, 1'b1, 3,  1, 1, 32'h3};
        REQ_VALID = '0; REQ_LOCK = '0; REQ_DATA = '0; PAR_EN_CFG = 1'b0;

        // Table-driven round-robin vectors.
        for (int v = 0; v < 8; v++) begin
            if (tv[v].rst) do_reset();
            PAR_EN_CFG = tv[v].par;
            tx_len = tv[v].len;
            set_data(tv[v].base);
            for (int i = 0; i < NR; i++) rem[i] = tv[v].valid[i] ? tv[v].cnt : 0;
            for (int j = 0; j < tv[v].n; j++) begin
                n = int'(tv[v].order[4*j +: 4]);
                push_exp(n, tv[v].base + 8'(n), tv[v].par);
            end
            a0 = ack_cnt; d0 = dv_cnt;
            drive_req();
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_acks", v), 32'(ack_cnt - a0), 32'(tv[v].n));
            check($sformatf("vec%0d_dvs", v), 32'(dv_cnt - d0), 32'(tv[v].n));
        end

        // TX never raises busy: timeout, drop, next requester served.
        do_reset();
        tx_dead = 1'b1; PAR_EN_CFG = 1'b1; set_data(8'h80);
        rem[0] = 2; rem[1] = 1;
        push_exp(0, 8'h80, 1'b1); push_exp(1, 8'h81, 1'b1); push_exp(0, 8'h80, 1'b1);
        a0 = ack_cnt; t0 = to_cnt;
        drive_req();
        for (int r = 0; r < 3; r++) begin
            n = 0;
            while (!TX_DATA_VALID && n < 100) begin tick(); n++; end
            check("to_dv_seen", 32'(n < 100), 32'd1);
            n = 0;
            while (!TIMEOUT_ERR && n < 100) begin tick(); n++; end
            check("to_latency", 32'(n), 32'(TO));
            check("to_arb_busy_at", 32'(ARB_BUSY), 32'd1);
            tick();
            check("to_arb_busy_after", 32'(ARB_BUSY), 32'd0);
            check("to_pulse_width", 32'(TIMEOUT_ERR), 32'd0);
        end
        wait_idle("to");
        check("to_count", 32'(to_cnt - t0), 32'd3);
        check("to_acks", 32'(ack_cnt - a0), 32'd3);

        // TX busy while idle: no grant until it clears.
        do_reset();
        tx_len = 4; tx_force = 1'b1; PAR_EN_CFG = 1'b0; set_data(8'hB0);
        rem[1] = 1; push_exp(1, 8'hB1, 1'b0);
        a0 = ack_cnt;
        drive_req();
        repeat (10) tick();
        check("busyidle_no_ack", 32'(ack_cnt - a0), 32'd0);
        check("busyidle_arb", 32'(ARB_BUSY), 32'd0);
        check("busyidle_grant", 32'(GRANT), 32'd0);
        tx_force = 1'b0;
        wait_idle("busyidle");
        check("busyidle_acks", 32'(ack_cnt - a0), 32'd1);

        // Reset in WAIT_LO: outputs clear at once, index 0 first afterwards.
        do_reset();
        tx_len = 20; PAR_EN_CFG = 1'b1; set_data(8'h90);
        rem[0] = 1; push_exp(0, 8'h90, 1'b1);
        drive_req();
        n = 0;
        while (!TX_BUSY && n < 100) begin tick(); n++; end
        tick(); tick();
        check("midrst_pre_busy", 32'(ARB_BUSY), 32'd1);
        check("midrst_pre_grant", 32'(GRANT), 32'd1);
        check("midrst_pre_data", 32'(TX_P_DATA), 32'h90);
        RST = 1'b0;
        #1;
        check_outputs_zero("midrst");
        tick();
        set_data(8'hA0);
        rem[0] = 1; rem[1] = 1;
        push_exp(0, 8'hA0, 1'b1); push_exp(1, 8'hA1, 1'b1);
        drive_req();
        RST = 1'b1;
        wait_idle("midrst_after");

        // Burst lock on requester 2.
        do_reset();
        tx_len = 3; PAR_EN_CFG = 1'b0; set_data(8'hC0);
        rem[1] = 1; push_exp(1, 8'hC1, 1'b0);
        drive_req();
        wait_idle("lock_setup");
        rem[0] = 1; rem[2] = 4; lock_cnt[2] = 3;
`ifdef UART_ARB_LOCK_EN
        push_exp(2, 8'hC2, 1'b0); push_exp(2, 8'hC2, 1'b0); push_exp(2, 8'hC2, 1'b0);
        push_exp(0, 8'hC0, 1'b0); push_exp(2, 8'hC2, 1'b0);
`else
        push_exp(2, 8'hC2, 1'b0); push_exp(0, 8'hC0, 1'b0); push_exp(2, 8'hC2, 1'b0);
        push_exp(2, 8'hC2, 1'b0); push_exp(2, 8'hC2, 1'b0);
`endif
        a0 = ack_cnt;
        drive_req();
        wait_idle("lock");
        check("lock_acks", 32'(ack_cnt - a0), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
